// File: rtl/mem_stage.sv
// mem_stage: pipeline stage directly downstream of execute.
//
// Performs the data-memory access for loads/stores over a req/ack handshake,
// stalling upstream while an access is outstanding, and retires every
// instruction to writeback with its data, register-write control and branch
// decision.
//
// Optional feature (macro MEM_MISALIGN_TRAP_EN): a word access with a
// non-zero address offset is not issued to memory; it retires with
// regwrite_out=0 and a one-cycle pulse on the extra 'misalign' output.
// Without the macro the low address bits are dropped and the aligned word
// is accessed.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   we                  upstream bundle valid (accepted when we=1 and stall=0)
//   regwrite_in .. dst_reg_in   execute-stage bundle
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be  memory request side
//   mem_rdata/mem_ack   memory response side (ack is a one-cycle pulse)
//   stall               upstream must hold its outputs
//   out_valid .. branch_target  retire bundle to writeback/fetch
//   bus_error           one-cycle pulse when the ack timeout expires
//   misalign            (MEM_MISALIGN_TRAP_EN only) misaligned word trap

module mem_stage #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic        regwrite_in,
    input  logic        do_read,
    input  logic        do_write,
    input  logic        is_byte,
    input  logic        memtoreg,
    input  logic        is_branch_in,
    input  logic        zero_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] data_store_in,
    input  logic [31:0] pc_branch_in,
    input  logic [4:0]  dst_reg_in,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        stall,
    output logic        out_valid,
    output logic        regwrite_out,
    output logic [4:0]  dst_reg_out,
    output logic [31:0] wb_data,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        bus_error
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    localparam logic [7:0] LastCnt = 8'(ACK_TIMEOUT - 1);

    state_e      r_state, w_state_d;
    logic [7:0]  r_cnt, w_cnt_d;

    // Latched input bundle for the memory access.
    logic        r_rw, w_rw_d;
    logic        r_rd, w_rd_d;
    logic        r_wr, w_wr_d;
    logic        r_byte, w_byte_d;
    logic        r_m2r, w_m2r_d;
    logic [31:0] r_addr, w_addr_d;
    logic [31:0] r_sdata, w_sdata_d;
    logic [4:0]  r_dst, w_dst_d;

    // Retire bundle.
    logic        r_out_valid, w_out_valid_d;
    logic        r_regwrite, w_regwrite_d;
    logic [4:0]  r_dst_out, w_dst_out_d;
    logic [31:0] r_wb_data, w_wb_data_d;
    logic        r_br_taken, w_br_taken_d;
    logic [31:0] r_br_target, w_br_target_d;
    logic        r_bus_error, w_bus_error_d;
    logic        r_misalign, w_misalign_d;

    logic        w_access;
    logic        w_mis;
    logic [7:0]  w_rbyte;
    logic [31:0] w_load_data;
    logic [31:0] w_wb_mem;

    assign w_access = (r_state == StAccess);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_mis = (do_read | do_write) & ~is_byte & (alu_result_in[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif

    // Memory-side outputs are driven only while an access is outstanding so
    // that the bus is quiet (all zero) in IDLE and during reset.
    always_comb begin
        mem_req   = w_access;
        stall     = w_access;
        mem_we    = w_access & r_wr;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_be    = 4'h0;
        if (w_access) begin
            mem_addr = {r_addr[31:2], 2'b00};
            if (r_byte) begin
                mem_be    = 4'b0001 << r_addr[1:0];
                mem_wdata = {4{r_sdata[7:0]}};
            end else begin
                mem_be    = 4'b1111;
                mem_wdata = r_sdata;
            end
        end
    end

    // Little-endian byte select and sign extension for byte loads.
    always_comb begin
        w_rbyte = mem_rdata[7:0];
        unique case (r_addr[1:0])
            2'b00: w_rbyte = mem_rdata[7:0];
            2'b01: w_rbyte = mem_rdata[15:8];
            2'b10: w_rbyte = mem_rdata[23:16];
            2'b11: w_rbyte = mem_rdata[31:24];
            default: w_rbyte = mem_rdata[7:0];
        endcase
        w_load_data = r_byte ? {{24{w_rbyte[7]}}, w_rbyte} : mem_rdata;
        // A store wins when both read and write are set.
        w_wb_mem = (r_rd & ~r_wr & r_m2r) ? w_load_data : r_addr;
    end

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_rw_d        = r_rw;
        w_rd_d        = r_rd;
        w_wr_d        = r_wr;
        w_byte_d      = r_byte;
        w_m2r_d       = r_m2r;
        w_addr_d      = r_addr;
        w_sdata_d     = r_sdata;
        w_dst_d       = r_dst;
        w_out_valid_d = 1'b0;
        w_regwrite_d  = r_regwrite;
        w_dst_out_d   = r_dst_out;
        w_wb_data_d   = r_wb_data;
        w_br_taken_d  = r_br_taken;
        w_br_target_d = r_br_target;
        w_bus_error_d = 1'b0;
        w_misalign_d  = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (we) begin
                    w_rw_d    = regwrite_in;
                    w_rd_d    = do_read;
                    w_wr_d    = do_write;
                    w_byte_d  = is_byte;
                    w_m2r_d   = memtoreg;
                    w_addr_d  = alu_result_in;
                    w_sdata_d = data_store_in;
                    w_dst_d   = dst_reg_in;
                    if (w_mis) begin
                        w_out_valid_d = 1'b1;
                        w_regwrite_d  = 1'b0;
                        w_dst_out_d   = dst_reg_in;
                        w_wb_data_d   = alu_result_in;
                        w_br_taken_d  = 1'b0;
                        w_misalign_d  = 1'b1;
                    end else if (do_read | do_write) begin
                        w_state_d = StAccess;
                        w_cnt_d   = 8'h0;
                    end else begin
                        w_out_valid_d = 1'b1;
                        w_regwrite_d  = regwrite_in;
                        w_dst_out_d   = dst_reg_in;
                        w_wb_data_d   = alu_result_in;
                        w_br_taken_d  = is_branch_in & zero_in;
                        w_br_target_d = pc_branch_in;
                    end
                end
            end
            StAccess: begin
                if (mem_ack) begin
                    w_state_d     = StIdle;
                    w_out_valid_d = 1'b1;
                    w_regwrite_d  = r_rw;
                    w_dst_out_d   = r_dst;
                    w_wb_data_d   = w_wb_mem;
                    w_br_taken_d  = 1'b0;
                end else if (r_cnt == LastCnt) begin
                    w_state_d     = StIdle;
                    w_out_valid_d = 1'b1;
                    w_regwrite_d  = 1'b0;
                    w_dst_out_d   = r_dst;
                    w_br_taken_d  = 1'b0;
                    w_bus_error_d = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + 8'h1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_cnt       <= 8'h0;
            r_rw        <= 1'b0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_byte      <= 1'b0;
            r_m2r       <= 1'b0;
            r_addr      <= 32'h0;
            r_sdata     <= 32'h0;
            r_dst       <= 5'h0;
            r_out_valid <= 1'b0;
            r_regwrite  <= 1'b0;
            r_dst_out   <= 5'h0;
            r_wb_data   <= 32'h0;
            r_br_taken  <= 1'b0;
            r_br_target <= 32'h0;
            r_bus_error <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_rw        <= w_rw_d;
            r_rd        <= w_rd_d;
            r_wr        <= w_wr_d;
            r_byte      <= w_byte_d;
            r_m2r       <= w_m2r_d;
            r_addr      <= w_addr_d;
            r_sdata     <= w_sdata_d;
            r_dst       <= w_dst_d;
            r_out_valid <= w_out_valid_d;
            r_regwrite  <= w_regwrite_d;
            r_dst_out   <= w_dst_out_d;
            r_wb_data   <= w_wb_data_d;
            r_br_taken  <= w_br_taken_d;
            r_br_target <= w_br_target_d;
            r_bus_error <= w_bus_error_d;
            r_misalign  <= w_misalign_d;
        end
    end

    // regwrite and branch_taken are only meaningful alongside out_valid.
    assign out_valid     = r_out_valid;
    assign regwrite_out  = r_regwrite & r_out_valid;
    assign dst_reg_out   = r_dst_out;
    assign wb_data       = r_wb_data;
    assign branch_taken  = r_br_taken & r_out_valid;
    assign branch_target = r_br_target;
    assign bus_error     = r_bus_error;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = r_misalign;
`else
    logic w_unused;
    assign w_unused = r_misalign;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int unsigned Timeout = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic        regwrite_in = 1'b0;
    logic        do_read = 1'b0;
    logic        do_write = 1'b0;
    logic        is_byte = 1'b0;
    logic        memtoreg = 1'b0;
    logic        is_branch_in = 1'b0;
    logic        zero_in = 1'b0;
    logic [31:0] alu_result_in = 32'h0;
    logic [31:0] data_store_in = 32'h0;
    logic [31:0] pc_branch_in = 32'h0;
    logic [4:0]  dst_reg_in = 5'h0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, stall, out_valid, regwrite_out, branch_taken, bus_error;
    logic [31:0] mem_addr, mem_wdata, wb_data, branch_target;
    logic [3:0]  mem_be;
    logic [4:0]  dst_reg_out;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage #(.ACK_TIMEOUT(Timeout)) dut (
        .clk(clk), .reset(reset), .we(we), .regwrite_in(regwrite_in),
        .do_read(do_read), .do_write(do_write), .is_byte(is_byte), .memtoreg(memtoreg),
        .is_branch_in(is_branch_in), .zero_in(zero_in), .alu_result_in(alu_result_in),
        .data_store_in(data_store_in), .pc_branch_in(pc_branch_in), .dst_reg_in(dst_reg_in),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .stall(stall),
        .out_valid(out_valid), .regwrite_out(regwrite_out), .dst_reg_out(dst_reg_out),
        .wb_data(wb_data), .branch_taken(branch_taken), .branch_target(branch_target),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw, rd, wr, byt, m2r, br, zero;
        logic [31:0] alu, sdata, pcb;
        logic [4:0]  dst;
        int          ack_dly;   // 0 = never ack
        logic [31:0] rdata;
        logic        e_mwe;
        logic [31:0] e_maddr, e_mwdata;
        logic [3:0]  e_mbe;
        logic [31:0] e_wb;
        logic        e_rw, e_bt, e_berr, chk_wb;
        logic [31:0] e_bt_tgt;
        logic        chk_tgt;
    } vec_t;

    typedef struct {
        logic [31:0] wb;
        logic [4:0]  dst;
        logic        rw, bt, berr, chk_wb, chk_tgt;
        logic [31:0] tgt;
        int          idx;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Scoreboard: every retire pops the oldest expected result.
    always @(negedge clk) begin
        if (reset && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_out_valid: got 1 expected 0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("v%0d_regwrite", e.idx), 32'(regwrite_out), 32'(e.rw));
                chk($sformatf("v%0d_dst", e.idx), 32'(dst_reg_out), 32'(e.dst));
                chk($sformatf("v%0d_branch_taken", e.idx), 32'(branch_taken), 32'(e.bt));
                chk($sformatf("v%0d_bus_error", e.idx), 32'(bus_error), 32'(e.berr));
                if (e.chk_wb) chk($sformatf("v%0d_wb_data", e.idx), wb_data, e.wb);
                if (e.chk_tgt) chk($sformatf("v%0d_target", e.idx), branch_target, e.tgt);
            end
        end
    end

    function automatic vec_t mk(input logic rw, rd, wr, byt, m2r, br, zero,
                                input logic [31:0] alu, sdata, pcb, input logic [4:0] dst,
                                input int dly, input logic [31:0] rdata,
                                input logic e_mwe, input logic [31:0] e_maddr, e_mwdata,
                                input logic [3:0] e_mbe, input logic [31:0] e_wb,
                                input logic e_rw, e_bt, e_berr, chk_wb);
        vec_t v;
        v.rw = rw; v.rd = rd; v.wr = wr; v.byt = byt; v.m2r = m2r; v.br = br; v.zero = zero;
        v.alu = alu; v.sdata = sdata; v.pcb = pcb; v.dst = dst; v.ack_dly = dly;
        v.rdata = rdata; v.e_mwe = e_mwe; v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
        v.e_mbe = e_mbe; v.e_wb = e_wb; v.e_rw = e_rw; v.e_bt = e_bt; v.e_berr = e_berr;
        v.chk_wb = chk_wb;
        v.chk_tgt = !(rd | wr);
        v.e_bt_tgt = pcb;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        we = 1'b1; regwrite_in = v.rw; do_read = v.rd; do_write = v.wr; is_byte = v.byt;
        memtoreg = v.m2r; is_branch_in = v.br; zero_in = v.zero; alu_result_in = v.alu;
        data_store_in = v.sdata; pc_branch_in = v.pcb; dst_reg_in = v.dst;
    endtask

    task automatic apply(input int idx, input vec_t v);
        exp_t e;
        int n;
        @(negedge clk);
        mem_ack = 1'b0;
        chk($sformatf("v%0d_pre_stall", idx), 32'(stall), 32'h0);
        chk($sformatf("v%0d_pre_mem_req", idx), 32'(mem_req), 32'h0);
        drive(v);
        e.wb = v.e_wb; e.dst = v.dst; e.rw = v.e_rw; e.bt = v.e_bt; e.berr = v.e_berr;
        e.chk_wb = v.chk_wb; e.chk_tgt = v.chk_tgt; e.tgt = v.e_bt_tgt; e.idx = idx;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        if (v.rd | v.wr) begin
            n = (v.ack_dly == 0) ? int'(Timeout) : v.ack_dly;
            for (int k = 1; k <= n; k++) begin
                if (k > 1) @(negedge clk);
                chk($sformatf("v%0d_stall_c%0d", idx, k), 32'(stall), 32'h1);
                if (k == 1) begin
                    chk($sformatf("v%0d_mem_req", idx), 32'(mem_req), 32'h1);
                    chk($sformatf("v%0d_mem_we", idx), 32'(mem_we), 32'(v.e_mwe));
                    chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.e_maddr);
                    chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.e_mwdata);
                    chk($sformatf("v%0d_mem_be", idx), 32'(mem_be), 32'(v.e_mbe));
                end
                if (k == v.ack_dly) begin
                    mem_ack = 1'b1;
                    mem_rdata = v.rdata;
                end
                @(posedge clk);
            end
        end else begin
            chk($sformatf("v%0d_alu_stall", idx), 32'(stall), 32'h0);
        end
    endtask

    initial begin
        // rw rd wr byt m2r br z  alu sdata pcb dst dly rdata | mwe maddr mwdata mbe wb rw bt berr chkwb
        vecs[0]  = mk(1,0,0,0,0,0,0, 32'h5, 32'h0, 32'h0, 5'd3, 0, 32'h0,
                      0, 32'h0, 32'h0, 4'h0, 32'h5, 1,0,0,1);
        vecs[1]  = mk(0,0,0,0,0,1,1, 32'h0, 32'h0, 32'h1000, 5'd0, 0, 32'h0,
                      0, 32'h0, 32'h0, 4'h0, 32'h0, 0,1,0,1);
        vecs[2]  = mk(0,0,0,0,0,1,0, 32'h4, 32'h0, 32'h2000, 5'd0, 0, 32'h0,
                      0, 32'h0, 32'h0, 4'h0, 32'h4, 0,0,0,1);
        vecs[3]  = mk(1,1,0,0,1,0,0, 32'h100, 32'h0, 32'h0, 5'd5, 3, 32'hDEADBEEF,
                      0, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF, 1,0,0,1);
        vecs[4]  = mk(0,0,1,1,0,0,0, 32'h203, 32'hA5, 32'h0, 5'd0, 1, 32'h0,
                      1, 32'h200, 32'hA5A5A5A5, 4'h8, 32'h203, 0,0,0,1);
        vecs[5]  = mk(1,1,0,1,1,0,0, 32'h101, 32'h0, 32'h0, 5'd7, 2, 32'h00008000,
                      0, 32'h100, 32'h0, 4'h2, 32'hFFFFFF80, 1,0,0,1);
        vecs[6]  = mk(0,1,1,0,0,0,0, 32'h300, 32'h12345678, 32'h0, 5'd0, 1, 32'h0,
                      1, 32'h300, 32'h12345678, 4'hF, 32'h300, 0,0,0,1);
        vecs[7]  = mk(1,1,0,0,1,0,0, 32'h500, 32'h0, 32'h0, 5'd9, 0, 32'h0,
                      0, 32'h500, 32'h0, 4'hF, 32'h0, 0,0,1,0);
        vecs[8]  = mk(1,1,0,1,1,0,0, 32'h102, 32'h0, 32'h0, 5'd10, 1, 32'h007F0000,
                      0, 32'h100, 32'h0, 4'h4, 32'h7F, 1,0,0,1);
        vecs[9]  = mk(1,1,0,0,0,0,0, 32'h404, 32'h0, 32'h0, 5'd11, 2, 32'h0000AAAA,
                      0, 32'h404, 32'h0, 4'hF, 32'h404, 1,0,0,1);
        vecs[10] = mk(1,1,0,1,1,0,0, 32'h103, 32'h0, 32'h0, 5'd12, 1, 32'h9A000000,
                      0, 32'h100, 32'h0, 4'h8, 32'hFFFFFF9A, 1,0,0,1);
        vecs[11] = mk(1,1,0,0,1,0,0, 32'h106, 32'h0, 32'h0, 5'd13, 2, 32'hCAFEF00D,
                      0, 32'h104, 32'h0, 4'hF, 32'hCAFEF00D, 1,0,0,1);

        // Reset state
        #2;
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_target", branch_target, 32'h0);
        chk("rst_bus_error", 32'(bus_error), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) apply(i, vecs[i]);

        // IDLE with we=0: outputs hold, a stray ack is ignored.
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = 32'h11111111;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_out_valid", 32'(out_valid), 32'h0);
        chk("idle_stall", 32'(stall), 32'h0);
        chk("idle_wb_hold", wb_data, 32'hCAFEF00D);
        chk("idle_dst_hold", 32'(dst_reg_out), 32'd13);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        // Reset asserted mid-ACCESS, then a late ack.
        drive(vecs[3]);
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        chk("mid_stall_before_rst", 32'(stall), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_mem_req", 32'(mem_req), 32'h0);
        chk("mid_rst_stall", 32'(stall), 32'h0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_wb_data", wb_data, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = 32'h22222222;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_out_valid", 32'(out_valid), 32'h0);
        chk("late_ack_stall", 32'(stall), 32'h0);
        chk("late_ack_wb_data", wb_data, 32'h0);

        // Post-reset ALU op still retires normally.
        apply(12, vecs[0]);
        @(negedge clk);
        @(negedge clk);
        chk("final_queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the execute stage's registered outputs: ALU result, store data, memory read/write and byte controls, memtoreg, branch/zero and destination register.
- Performs the data-memory access over a req/ack handshake, stalling upstream while the access is outstanding.
- Delivers writeback data, register-write controls and the branch decision to the writeback stage and the fetch stage.

Parameters:
ACK_TIMEOUT, 16, cycles waited in ACCESS for mem_ack before aborting with bus_error (valid range 2..255)

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  asynchronous, active-low reset (asserted when 0)
we  in  1  upstream stage-enable; input bundle accepted only when we=1 and stall=0
regwrite_in  in  1  register write permission
do_read  in  1  load
do_write  in  1  store
is_byte  in  1  byte access (else word)
memtoreg  in  1  writeback selects memory data (else ALU result)
is_branch_in  in  1  instruction is a conditional branch
zero_in  in  1  ALU zero flag
alu_result_in  in  32  address for memory ops / result otherwise
data_store_in  in  32  store data
pc_branch_in  in  32  branch target
dst_reg_in  in  5  destination register
mem_rdata  in  32  memory read data, valid when mem_ack=1
mem_ack  in  1  memory completion, single-cycle pulse
mem_req  out  1  memory request, held until ack
mem_we  out  1  1=store, 0=load
mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
mem_wdata  out  32  store data, byte lane-replicated for byte stores
mem_be  out  4  byte enables
stall  out  1  upstream must hold its outputs
out_valid  out  1  one-cycle pulse per retired instruction
regwrite_out  out  1  register write, qualified by out_valid
dst_reg_out  out  5  destination register
wb_data  out  32  writeback data
branch_taken  out  1  is_branch & zero, qualified by out_valid
branch_target  out  32  registered pc_branch_in
bus_error  out  1  one-cycle pulse on ack timeout

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs 0, including mem_req, stall, out_valid, wb_data, branch_target, bus_error. Timeout counter 0.
  - Reset mid-ACCESS drops mem_req immediately.
  - A late mem_ack after reset is ignored.
- FSM states: IDLE, ACCESS. stall = (state==ACCESS), combinational.
- IDLE, accept edge (we=1): latch the input bundle.
  - do_read|do_write=1: go to ACCESS; out_valid<=0.
  - Otherwise: 1-cycle latency. out_valid<=1, wb_data<=alu_result_in, regwrite_out<=regwrite_in, dst_reg_out, branch_taken<=is_branch_in&zero_in, branch_target<=pc_branch_in.
- IDLE, we=0: out_valid<=0; all other outputs hold.
- ACCESS outputs: mem_req=1, driven from latched fields.
  - mem_we=latched do_write.
  - mem_be: word → 4'b1111; byte → one-hot at addr[1:0] (little-endian, 00→4'b0001).
  - mem_wdata: word → store data; byte → {4{data[7:0]}}.
- ACCESS, edge with mem_ack=1: return to IDLE. out_valid<=1, regwrite_out<=latched regwrite, branch_taken<=0.
  - wb_data: load with memtoreg=1 → memory data; otherwise alu_result.
  - Byte load: selected byte at addr[1:0], sign-extended to 32.
- ACCESS, no ack: counter increments every cycle.
  - Counter reaching ACK_TIMEOUT-1 with no ack: bus_error<=1 for one cycle, out_valid<=1, regwrite_out<=0, return to IDLE.
  - Counter clears on entry to ACCESS.
- do_read and do_write both 1: treated as a store.
- Back-to-back: a new bundle is accepted in the IDLE cycle following ACCESS exit. mem_req drops for at least one cycle between accesses.
- mem_ack while in IDLE: ignored.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- When defined: a word access with addr[1:0]≠0 does not enter ACCESS and does not assert mem_req. It retires next edge with out_valid=1, regwrite_out=0, and an extra output port misalign (1 bit) pulsed high for one cycle.
- When undefined: no misalign port; the address low bits are silently dropped and the aligned word is accessed.

Test Plan:
1. Reset low mid-ACCESS with mem_req=1 → mem_req, stall, out_valid go 0 without a clock edge; after release, state IDLE.
2. ALU op, we=1, alu_result_in=0x00000005, dst=3, regwrite=1 → next edge: out_valid=1, wb_data=0x5, dst_reg_out=3, stall never 1.
3. Word load addr 0x100, mem_ack 3 cycles later with rdata 0xDEADBEEF → stall high 3 cycles, mem_be=1111, then wb_data=0xDEADBEEF, regwrite_out=1.
4. Byte store addr 0x203, data 0x000000A5 → mem_addr=0x200, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1.
5. Byte load addr 0x101, rdata 0x00008000 → wb_data=0xFFFFFF80.
6. Load with no ack, ACK_TIMEOUT=4 → bus_error pulse after 4 ACCESS cycles, out_valid=1, regwrite_out=0, stall drops.
